// File: rtl/sync_fifo_flags.sv
// Single-clock elastic FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and an optional
// first-word-fall-through read mode.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - asynchronous active-low reset (clears pointers, count, DOUT, errors)
//   writeEN/DIN  - write request and data
//   readEN       - read (pop) request
//   err_clr      - synchronous clear of overflow/underflow (a new error wins)
//   DOUT         - read data (registered in standard mode, combinational in FWFT)
//   empty/full   - count == 0 / count == depth
//   almost_empty - count <= ae_level
//   almost_full  - count >= af_level
//   count        - current occupancy
//   overflow     - sticky: a write was rejected
//   underflow    - sticky: a read was rejected
module sync_fifo_flags #(
  parameter int unsigned data_size = 8,
  parameter int unsigned depth     = 8,
  parameter int unsigned af_level  = depth - 2,
  parameter int unsigned ae_level  = 2,
  parameter bit          fwft      = 1'b0,
  localparam int unsigned CntW     = $clog2(depth + 1),
  localparam int unsigned PtrW     = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 writeEN,
  input  logic [data_size-1:0] DIN,
  input  logic                 readEN,
  input  logic                 err_clr,
  output logic [data_size-1:0] DOUT,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [CntW-1:0]      count,
  output logic                 overflow,
  output logic                 underflow
);

  logic [data_size-1:0] mem [depth];

  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [data_size-1:0] dout_q;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 rd_ok, wr_ok;

  // Flags come straight from the registered count, so no request input
  // reaches any output combinationally.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CntW'(depth));
  assign almost_empty = (count_q <= CntW'(ae_level));
  assign almost_full  = (count_q >= CntW'(af_level));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A pop at full frees the slot the simultaneous push lands in.
  assign rd_ok = readEN & ~empty;
  assign wr_ok = writeEN & (~full | rd_ok);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) begin
      wptr_d = (wptr_q == PtrW'(depth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d = (rptr_q == PtrW'(depth - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  // Sticky errors; a new error in the clearing cycle takes priority.
  always_comb begin
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (writeEN && !wr_ok) ovf_d = 1'b1;
    if (readEN && !rd_ok)  unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (!fwft && rd_ok) begin
        dout_q <= mem[rptr_q];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr_q] <= DIN;
    end
  end

  assign DOUT = fwft ? mem[rptr_q] : dout_q;

endmodule
